// File: rtl/mux_nto1_rr.sv
// N-to-1 registered multiplexer: external select (MODE=0) or round-robin arbitration (MODE=1).
// Optional sticky out-of-range select flag on port err when MUX_SEL_ERR_EN is defined.
module mux_nto1_rr #(
    parameter int WIDTH = 2,
    parameter int N     = 4,
    parameter int MODE  = 0,
    localparam int SELW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef MUX_SEL_ERR_EN
    output logic                 err,
`endif
    output logic [SELW-1:0]      grant
);

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [SELW-1:0]  r_grant;
    logic [SELW-1:0]  r_last;

    logic             w_load_en;
    logic             w_sel_ok;
    logic             w_found;
    logic             w_xfer;
    logic [SELW-1:0]  w_chosen;
    logic [SELW-1:0]  w_idx;
    logic [N-1:0]     w_ready;
    logic [WIDTH-1:0] w_data;

    assign w_load_en = !r_out_valid || out_ready;
    assign w_sel_ok  = ({1'b0, sel} < (SELW+1)'(N));

    // Round-robin scans from last+1 with wrap; the first valid channel found wins.
    always_comb begin
        w_chosen = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        if (MODE == 1) begin
            for (int unsigned k = 1; k <= N; k++) begin
                w_idx = SELW'((32'(r_last) + k) % N);
                if (!w_found && in_valid[w_idx]) begin
                    w_found  = 1'b1;
                    w_chosen = w_idx;
                end
            end
        end else begin
            w_chosen = sel;
            w_found  = w_sel_ok;
        end
    end

    always_comb begin
        w_ready = '0;
        w_data  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_ready[i] = !reset && w_load_en && w_found && (w_chosen == SELW'(i));
            if (w_chosen == SELW'(i)) begin
                w_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_xfer = |(in_valid & w_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_grant     <= '0;
            r_last      <= SELW'(N - 1);
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data;
            r_grant     <= w_chosen;
            if (MODE == 1) begin
                r_last <= w_chosen;
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef MUX_SEL_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if ((MODE == 0) && !w_sel_ok && w_load_en) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

    assign in_ready  = w_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign grant     = r_grant;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Directed bench for mux_nto1_rr: external-select table, round-robin sequences, reset and out-of-range select.
module tb_mux_nto1_rr;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // a_: MODE=0 N=4, b_: MODE=1 N=4, c_: MODE=0 N=3
    logic [7:0] a_data;  logic [3:0] a_valid; logic [3:0] a_rdy; logic [1:0] a_sel;
    logic [1:0] a_od;    logic a_ov; logic a_ordy; logic [1:0] a_gr;
    logic [7:0] b_data;  logic [3:0] b_valid; logic [3:0] b_rdy; logic [1:0] b_sel;
    logic [1:0] b_od;    logic b_ov; logic b_ordy; logic [1:0] b_gr;
    logic [5:0] c_data;  logic [2:0] c_valid; logic [2:0] c_rdy; logic [1:0] c_sel;
    logic [1:0] c_od;    logic c_ov; logic c_ordy; logic [1:0] c_gr;
`ifdef MUX_SEL_ERR_EN
    logic a_err, b_err, c_err;
`endif

    mux_nto1_rr #(.WIDTH(2), .N(4), .MODE(0)) u_a (
        .clk(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid), .in_ready(a_rdy),
        .sel(a_sel), .out_data(a_od), .out_valid(a_ov), .out_ready(a_ordy),
`ifdef MUX_SEL_ERR_EN
        .err(a_err),
`endif
        .grant(a_gr));

    mux_nto1_rr #(.WIDTH(2), .N(4), .MODE(1)) u_b (
        .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid), .in_ready(b_rdy),
        .sel(b_sel), .out_data(b_od), .out_valid(b_ov), .out_ready(b_ordy),
`ifdef MUX_SEL_ERR_EN
        .err(b_err),
`endif
        .grant(b_gr));

    mux_nto1_rr #(.WIDTH(2), .N(3), .MODE(0)) u_c (
        .clk(clk), .reset(reset), .in_data(c_data), .in_valid(c_valid), .in_ready(c_rdy),
        .sel(c_sel), .out_data(c_od), .out_valid(c_ov), .out_ready(c_ordy),
`ifdef MUX_SEL_ERR_EN
        .err(c_err),
`endif
        .grant(c_gr));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] sel;
        logic [3:0] valid;
        logic [7:0] data;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [1:0] exp_od;
        logic [1:0] exp_gr;
    } vec_t;

    vec_t tbl [8];
    logic [1:0] exp_gr [8];
    logic [3:0] onehot;

    initial begin
        tbl[0] = '{2'd2, 4'b1111, 8'b00_11_10_01, 1'b1, 4'b0100, 1'b1, 2'b11, 2'd2};
        tbl[1] = '{2'd1, 4'b1111, 8'b00_11_10_01, 1'b0, 4'b0000, 1'b1, 2'b11, 2'd2};
        tbl[2] = '{2'd1, 4'b1111, 8'b00_11_10_01, 1'b1, 4'b0010, 1'b1, 2'b10, 2'd1};
        tbl[3] = '{2'd0, 4'b0000, 8'b00_11_10_01, 1'b1, 4'b0001, 1'b0, 2'b10, 2'd1};
        tbl[4] = '{2'd3, 4'b1000, 8'b01_00_00_00, 1'b0, 4'b1000, 1'b1, 2'b01, 2'd3};
        tbl[5] = '{2'd0, 4'b0001, 8'b00_00_00_11, 1'b0, 4'b0000, 1'b1, 2'b01, 2'd3};
        tbl[6] = '{2'd0, 4'b0001, 8'b00_00_00_11, 1'b1, 4'b0001, 1'b1, 2'b11, 2'd0};
        tbl[7] = '{2'd2, 4'b1011, 8'b11_00_11_11, 1'b1, 4'b0100, 1'b0, 2'b11, 2'd0};
        exp_gr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

        a_data = '0; a_valid = '0; a_sel = '0; a_ordy = 1'b0;
        b_data = '0; b_valid = '0; b_sel = '0; b_ordy = 1'b0;
        c_data = '0; c_valid = '0; c_sel = '0; c_ordy = 1'b0;

        step();
        step();
        check("rst_ov", 32'(a_ov), 32'd0);
        check("rst_od", 32'(a_od), 32'd0);
        check("rst_gr", 32'(a_gr), 32'd0);
        reset = 1'b0;
        #1;

        for (int v = 0; v < 8; v++) begin
            a_sel = tbl[v].sel; a_valid = tbl[v].valid; a_data = tbl[v].data; a_ordy = tbl[v].ordy;
            #1;
            check($sformatf("sel_rdy[%0d]", v), 32'(a_rdy), 32'(tbl[v].exp_rdy));
            step();
            check($sformatf("sel_ov[%0d]", v), 32'(a_ov), 32'(tbl[v].exp_ov));
            check($sformatf("sel_od[%0d]", v), 32'(a_od), 32'(tbl[v].exp_od));
            check($sformatf("sel_gr[%0d]", v), 32'(a_gr), 32'(tbl[v].exp_gr));
        end
`ifdef MUX_SEL_ERR_EN
        check("sel_err_quiet", 32'(a_err), 32'd0);
`endif
        a_valid = '0;

        // Round-robin, all channels valid: one beat per cycle, grants rotate from 0
        b_data = 8'b11_10_01_00; b_valid = 4'b1111; b_ordy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            onehot = 4'(1 << (k % 4));
            check($sformatf("rr_rdy[%0d]", k), 32'(b_rdy), 32'(onehot));
            step();
            check($sformatf("rr_gr[%0d]", k), 32'(b_gr), 32'(exp_gr[k]));
            check($sformatf("rr_ov[%0d]", k), 32'(b_ov), 32'd1);
            check($sformatf("rr_od[%0d]", k), 32'(b_od), 32'(exp_gr[k]));
        end

        // Drain with no valid input
        b_valid = 4'b0000;
        #1;
        check("drain_rdy", 32'(b_rdy), 32'd0);
        step();
        check("drain_ov", 32'(b_ov), 32'd0);
        check("drain_gr", 32'(b_gr), 32'd3);

        // Channels 1 and 3 only, with back-pressure after the first beat
        b_valid = 4'b1010;
        #1;
        check("bp_rdy0", 32'(b_rdy), 32'b0010);
        step();
        check("bp_gr0", 32'(b_gr), 32'd1);
        check("bp_od0", 32'(b_od), 32'd1);
        b_ordy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_hold_rdy[%0d]", k), 32'(b_rdy), 32'd0);
            step();
            check($sformatf("bp_hold_ov[%0d]", k), 32'(b_ov), 32'd1);
            check($sformatf("bp_hold_gr[%0d]", k), 32'(b_gr), 32'd1);
            check($sformatf("bp_hold_od[%0d]", k), 32'(b_od), 32'd1);
        end
        b_ordy = 1'b1;
        #1;
        check("bp_rdy1", 32'(b_rdy), 32'b1000);
        step();
        check("bp_gr1", 32'(b_gr), 32'd3);
        check("bp_od1", 32'(b_od), 32'd3);

        // Reset while a beat is held; loading conditions are present but must be ignored
        b_valid = 4'b1111; b_ordy = 1'b0;
        step();
        check("pre_rst_ov", 32'(b_ov), 32'd1);
        reset = 1'b1; b_ordy = 1'b1;
        #1;
        check("rst_mid_rdy", 32'(b_rdy), 32'd0);
        step();
        check("rst_mid_ov", 32'(b_ov), 32'd0);
        check("rst_mid_od", 32'(b_od), 32'd0);
        check("rst_mid_gr", 32'(b_gr), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_rdy", 32'(b_rdy), 32'b0001);
        step();
        check("post_rst_gr", 32'(b_gr), 32'd0);
        check("post_rst_ov", 32'(b_ov), 32'd1);
        b_valid = '0;

        // N=3: out-of-range select accepts nothing
        c_data = 6'b10_01_11; c_valid = 3'b111; c_ordy = 1'b1; c_sel = 2'd3;
        #1;
        check("oor_rdy", 32'(c_rdy), 32'd0);
        step();
        check("oor_ov", 32'(c_ov), 32'd0);
`ifdef MUX_SEL_ERR_EN
        check("oor_err", 32'(c_err), 32'd1);
`endif
        c_sel = 2'd0;
        #1;
        check("inr_rdy", 32'(c_rdy), 32'b001);
        step();
        check("inr_ov", 32'(c_ov), 32'd1);
        check("inr_od", 32'(c_od), 32'b11);
        check("inr_gr", 32'(c_gr), 32'd0);
`ifdef MUX_SEL_ERR_EN
        check("err_sticky", 32'(c_err), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("err_cleared", 32'(c_err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
